// File: rtl/rtl_control_fsm.sv
// Control unit for a small CPU with two-byte instructions: fetches both bytes, executes
// one opcode, and keeps the sticky halt/illegal flags and the retired-instruction count.
module rtl_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic [7:0] regData,
   input  logic       memReady,
   output logic       memReq,
   output logic       memWrite,
   output logic       pcSelect,
   output logic       pcEnable,
   output logic       adrSelect,
   output logic       ir1En,
   output logic       ir2En,
   output logic       regSelect,
   output logic       wd3Select,
   output logic       regWrite,
   output logic       op1Sel,
   output logic       op2Sel,
   output logic       aluOutEn,
   output logic [2:0] aluControl,
   output logic       halted,
   output logic       illegal,
   output logic [7:0] instrCount,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_FETCH1 = 2'd0,
      S_FETCH2 = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;

   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_INC = 4'h6;
   localparam logic [3:0] OP_LD  = 4'h7;
   localparam logic [3:0] OP_ST  = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_JNZ = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic       halted_q, halted_d;
   logic       illegal_q, illegal_d;

   function automatic logic [2:0] alu_code(input logic [3:0] op);
      logic [2:0] code;
      case (op)
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         OP_XOR:  code = ALU_XOR;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH1;
         count_q   <= 8'd0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   // Memory handshake: memReq (with adrSelect/memWrite) is a valid that stays stable until
   // the cycle memReady is high, which completes the transfer; memReady means nothing
   // in any cycle where memReq is low.
   always_comb begin
      memReq     = 1'b0;
      memWrite   = 1'b0;
      pcSelect   = 1'b0;
      pcEnable   = 1'b0;
      adrSelect  = 1'b0;
      ir1En      = 1'b0;
      ir2En      = 1'b0;
      regSelect  = 1'b0;
      wd3Select  = 1'b0;
      regWrite   = 1'b0;
      op1Sel     = 1'b0;
      op2Sel     = 1'b0;
      aluOutEn   = 1'b0;
      aluControl = ALU_ADD;
      state_d    = state_q;
      count_d    = count_q;
      halted_d   = halted_q;
      illegal_d  = illegal_q;

      // Outputs are forced quiet for as long as reset is held, not just at the next edge.
      if (reset) begin
         case (state_q)
            S_FETCH1: begin
               memReq = 1'b1;
               op2Sel = 1'b1;
               if (memReady) begin
                  ir1En    = 1'b1;
                  pcEnable = 1'b1;
                  state_d  = S_FETCH2;
               end
            end
            S_FETCH2: begin
               memReq = 1'b1;
               op2Sel = 1'b1;
               if (memReady) begin
                  ir2En    = 1'b1;
                  pcEnable = 1'b1;
                  state_d  = S_EXEC;
               end
            end
            S_EXEC: begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                     regSelect  = 1'b1;
                     op1Sel     = 1'b1;
                     wd3Select  = 1'b1;
                     regWrite   = 1'b1;
                     aluOutEn   = 1'b1;
                     aluControl = alu_code(opcode);
                     state_d    = S_FETCH1;
                  end
                  OP_INC: begin
                     regSelect = 1'b1;
                     op1Sel    = 1'b1;
                     op2Sel    = 1'b1;
                     wd3Select = 1'b1;
                     regWrite  = 1'b1;
                     aluOutEn  = 1'b1;
                     state_d   = S_FETCH1;
                  end
                  OP_LD: begin
                     memReq    = 1'b1;
                     adrSelect = 1'b1;
                     if (memReady) begin
                        regWrite = 1'b1;
                        state_d  = S_FETCH1;
                     end
                  end
                  OP_ST: begin
                     memReq    = 1'b1;
                     memWrite  = 1'b1;
                     adrSelect = 1'b1;
                     if (memReady) begin
                        state_d = S_FETCH1;
                     end
                  end
                  OP_JMP: begin
                     pcSelect = 1'b1;
                     pcEnable = 1'b1;
                     state_d  = S_FETCH1;
                  end
                  OP_JZ: begin
                     if (regData == 8'd0) begin
                        pcSelect = 1'b1;
                        pcEnable = 1'b1;
                     end
                     state_d = S_FETCH1;
                  end
                  OP_JNZ: begin
                     if (regData != 8'd0) begin
                        pcSelect = 1'b1;
                        pcEnable = 1'b1;
                     end
                     state_d = S_FETCH1;
                  end
                  OP_HLT: begin
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end
                  4'hC, 4'hD, 4'hE: begin
                     halted_d  = 1'b1;
                     illegal_d = 1'b1;
                     state_d   = S_HALT;
                  end
                  default: begin
                     state_d = S_FETCH1;
                  end
               endcase
               // An instruction retires exactly when EXEC hands back to fetch.
               if (state_d == S_FETCH1) begin
                  count_d = count_q + 8'd1;
               end
            end
            S_HALT: begin
               state_d = S_HALT;
            end
            default: begin
               state_d = S_FETCH1;
            end
         endcase
      end
   end

   assign halted     = halted_q;
   assign illegal    = illegal_q;
   assign instrCount = count_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_rtl_control_fsm.sv
// Bench for rtl_control_fsm: directed scenarios plus random opcode/memReady/reset traffic,
// every cycle checked against an instruction-level model of the control unit.
module tb_rtl_control_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic [7:0] regData = 8'h00;
   logic       memReady = 1'b0;
   logic       memReq, memWrite, pcSelect, pcEnable, adrSelect, ir1En, ir2En;
   logic       regSelect, wd3Select, regWrite, op1Sel, op2Sel, aluOutEn;
   logic [2:0] aluControl;
   logic       halted, illegal;
   logic [7:0] instrCount;
   logic [1:0] state_dbg;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: which byte/phase of the current instruction we are in, plus status.
   // phase 0 = first byte fetch, 1 = second byte fetch, 2 = execute, 3 = stopped.
   int m_phase = 0;
   int m_count = 0;
   bit m_halted = 1'b0;
   bit m_illegal = 1'b0;

   rtl_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .regData(regData), .memReady(memReady),
      .memReq(memReq), .memWrite(memWrite), .pcSelect(pcSelect), .pcEnable(pcEnable),
      .adrSelect(adrSelect), .ir1En(ir1En), .ir2En(ir2En), .regSelect(regSelect),
      .wd3Select(wd3Select), .regWrite(regWrite), .op1Sel(op1Sel), .op2Sel(op2Sel),
      .aluOutEn(aluOutEn), .aluControl(aluControl), .halted(halted), .illegal(illegal),
      .instrCount(instrCount), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
      end
   endtask

   // Expected control word {memReq,memWrite,pcSelect,pcEnable,adrSelect,ir1En,ir2En,
   // regSelect,wd3Select,regWrite,op1Sel,op2Sel,aluOutEn,aluControl[2:0]}.
   function automatic logic [15:0] exp_ctrl(input int ph, input logic [3:0] op,
                                              input logic rdy, input logic [7:0] rd);
      bit mr = 0, mw = 0, ps = 0, pe = 0, as = 0, i1 = 0, i2 = 0;
      bit rs = 0, wd = 0, rw = 0, o1 = 0, o2 = 0, ao = 0;
      logic [2:0] alu = 3'd0;
      if (ph == 0 || ph == 1) begin
         mr = 1; o2 = 1;
         if (rdy) begin
            pe = 1;
            if (ph == 0) i1 = 1; else i2 = 1;
         end
      end else if (ph == 2) begin
         if (op >= 4'h1 && op <= 4'h6) begin
            rs = 1; o1 = 1; wd = 1; rw = 1; ao = 1;
            if (op == 4'h6) o2 = 1;
            else alu = 3'(int'(op) - 1);
         end else if (op == 4'h7) begin
            mr = 1; as = 1; rw = rdy;
         end else if (op == 4'h8) begin
            mr = 1; mw = 1; as = 1;
         end else if (op == 4'h9) begin
            ps = 1; pe = 1;
         end else if ((op == 4'hA && rd == 0) || (op == 4'hB && rd != 0)) begin
            ps = 1; pe = 1;
         end
      end
      return {mr, mw, ps, pe, as, i1, i2, rs, wd, rw, o1, o2, ao, alu};
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase = 0; m_count = 0; m_halted = 0; m_illegal = 0;
      end else begin
         case (m_phase)
            0: if (memReady) m_phase = 1;
            1: if (memReady) m_phase = 2;
            2: begin
               if (opcode == 4'hF) begin
                  m_phase = 3; m_halted = 1;
               end else if (opcode >= 4'hC) begin
                  m_phase = 3; m_halted = 1; m_illegal = 1;
               end else if (!((opcode == 4'h7 || opcode == 4'h8) && !memReady)) begin
                  m_phase = 0; m_count = (m_count + 1) % 256;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("ctrl",
          {memReq, memWrite, pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect,
           wd3Select, regWrite, op1Sel, op2Sel, aluOutEn, aluControl},
          reset ? exp_ctrl(m_phase, opcode, memReady, regData) : 16'h0000);
      chk("instrCount", 16'(instrCount), 16'(m_count));
      chk("flags", 16'({halted, illegal}), 16'({m_halted, m_illegal}));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      step();
      @(negedge clk);
      chk("rst_state", 16'({memReq, halted, illegal, instrCount}), 16'h0000);

      // ADD: three cycles, one retired instruction.
      step();
      do_reset();
      opcode = 4'h1; memReady = 1'b1; regData = 8'h45;
      step(); step();
      @(negedge clk);
      chk("add_exec", 16'({regSelect, regWrite, wd3Select, aluControl}), 16'h0038);
      step();
      @(negedge clk);
      chk("add_count", 16'(instrCount), 16'd1);

      // Fetch wait states.
      step();
      do_reset();
      opcode = 4'h0; memReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("wait_f1", 16'({memReq, ir1En, pcEnable}), 16'h0004);
         step();
      end
      memReady = 1'b1;
      @(negedge clk);
      chk("wait_done", 16'({memReq, ir1En, pcEnable}), 16'h0007);

      // JZ taken then not taken.
      step();
      do_reset();
      opcode = 4'hA; memReady = 1'b1; regData = 8'h00;
      step(); step();
      @(negedge clk);
      chk("jz_taken", 16'({pcSelect, pcEnable}), 16'h0003);
      step(); step(); step();
      regData = 8'h01;
      @(negedge clk);
      chk("jz_not", 16'({pcSelect, pcEnable}), 16'h0000);
      step();
      @(negedge clk);
      chk("jz_count", 16'(instrCount), 16'd2);

      // Store with two wait cycles.
      step();
      do_reset();
      opcode = 4'h8; memReady = 1'b1;
      step(); step();
      memReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) memReady = 1'b1;
         @(negedge clk);
         chk("st_wait", 16'({memReq, memWrite, adrSelect, regWrite}), 16'h000E);
         step();
      end
      @(negedge clk);
      chk("st_done", 16'({memWrite, adrSelect, ir1En, instrCount}), 16'h0101);

      // Illegal opcode halts; asynchronous reset clears it.
      step();
      do_reset();
      opcode = 4'hD; memReady = 1'b1;
      step(); step(); step();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("halt_flags", 16'({halted, illegal, memReq, pcEnable, regWrite}), 16'h0018);
         step();
      end
      @(negedge clk);
      #1 reset = 1'b0;
      #1 chk("halt_rst", 16'({halted, illegal, memReq, instrCount}), 16'h0000);
      step();
      reset = 1'b1;
      opcode = 4'h0;
      @(negedge clk);
      chk("rst_fetch1", 16'({memReq, ir1En}), 16'h0003);

      // Count wrap.
      step();
      do_reset();
      opcode = 4'h0; memReady = 1'b1;
      repeat (255 * 3) step();
      @(negedge clk);
      chk("count_ff", 16'(instrCount), 16'h00FF);
      repeat (3) step();
      @(negedge clk);
      chk("count_wrap", 16'(instrCount), 16'h0000);

      // Random traffic.
      step();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         step();
         if (!reset) reset = 1'b1;
         else if ((m_phase == 3 && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0)
            reset = 1'b0;
         if ($urandom_range(0, 99) < 4) opcode = 4'($urandom_range(12, 15));
         else opcode = 4'($urandom_range(0, 11));
         memReady = ($urandom_range(0, 9) < 7);
         regData = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      end
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rtl_control_fsm.md
RTL_CONTROL_FSM -- requirements
Module: rtl_control_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; reset=0 forces reset state immediately, independent of clk.
REQ-003 SHALL have ports: opcode  in  4  current instruction opcode (ir1[7:4]).
REQ-004 SHALL have ports: regData  in  8  rd1 of register file (datapath memWD), used for branch test.
REQ-005 SHALL have ports: memReady  in  1  memory access completes this cycle.
REQ-006 SHALL have ports: memReq, memWrite  out  1 each  memory access request / write strobe.
REQ-007 SHALL have ports: pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect, wd3Select, regWrite, op1Sel, op2Sel, aluOutEn  out  1 each  datapath controls.
REQ-008 SHALL have ports: aluControl  out  3  ALU op (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR).
REQ-009 SHALL have ports: halted, illegal  out  1 each  sticky status; instrCount  out  8  retired-instruction count.

Function
REQ-010 SHALL implement states FETCH1, FETCH2, EXEC, HALT; every instruction is two bytes.
REQ-011 FETCH1: memReq=1, adrSelect=0, op1Sel=0, op2Sel=1, aluControl=ADD; when memReady=1: ir1En=1, pcEnable=1, pcSelect=0, next FETCH2; else hold, all enables 0.
REQ-012 FETCH2: same as FETCH1 but ir2En instead of ir1En; on memReady=1 next EXEC.
REQ-013 EXEC ALU ops (1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR): regSelect=1, op1Sel=1, op2Sel=0, wd3Select=1, regWrite=1, aluOutEn=1, aluControl per REQ-008; one cycle; next FETCH1.
REQ-014 EXEC 6 INC: as REQ-013 but op2Sel=1, aluControl=ADD.
REQ-015 EXEC 7 LD: memReq=1, adrSelect=1, wd3Select=0; regWrite=1 only in cycle memReady=1; hold in EXEC until then.
REQ-016 EXEC 8 ST: memReq=1, memWrite=1, adrSelect=1, regSelect=0; hold until memReady=1; regWrite=0.
REQ-017 EXEC 9 JMP: pcSelect=1, pcEnable=1; one cycle.
REQ-018 EXEC A JZ / B JNZ: regSelect=0; taken when regData==0 (JZ) or !=0 (JNZ): pcSelect=1, pcEnable=1; not taken: no enables.
REQ-019 EXEC 0 NOP: no enables, one cycle.
REQ-020 EXEC F HLT: next HALT, halted set; opcodes C-E: next HALT, halted and illegal set.
REQ-021 HALT: all enables, memReq, memWrite 0; remains until reset.
REQ-022 Outputs not listed as asserted in a state SHALL be 0 (aluControl 000).
REQ-023 memWrite SHALL never be 1 while memReq=0; memReq held constant (with address select) until memReady=1.
REQ-024 instrCount SHALL increment on leaving EXEC to FETCH1 (incl. NOP, taken/untaken branches; excl. HLT/illegal); wraps 255->0.
REQ-025 memReady SHALL be ignored outside memory states (FETCH1, FETCH2, EXEC with LD/ST).

Reset
REQ-026 reset=0 SHALL asynchronously set state FETCH1, halted=0, illegal=0, instrCount=0; all enables, memReq, memWrite 0 while reset=0.
REQ-027 Reset mid-instruction (incl. pending memory wait) SHALL abort it with no further write; first cycle after release is FETCH1.

Verification
REQ-028 ADD: memReady tied 1, bytes 0x13,0x45 -> FETCH1,FETCH2,EXEC; EXEC: regSelect=1, regWrite=1, wd3Select=1, aluControl=000; instrCount 0->1.
REQ-029 Wait states: FETCH1 with memReady=0 for 3 cycles -> memReq=1, ir1En=0, pcEnable=0 for 3 cycles, then ir1En=pcEnable=1 one cycle.
REQ-030 JZ: opcode A, regData=0x00 -> pcSelect=1, pcEnable=1; regData=0x01 -> pcEnable=0; both increment instrCount.
REQ-031 ST with memReady low 2 cycles -> memReq=memWrite=adrSelect=1 for 3 cycles, regWrite=0, then FETCH1.
REQ-032 Opcode 0xD -> HALT, halted=1, illegal=1, no enables for 10 cycles; reset=0 mid-cycle -> immediate FETCH1, flags 0.
REQ-033 255 NOPs then one more -> instrCount 0xFF then 0x00.
